conv_window_feeder: RTL and testbench

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_window_feeder_if.sv | 24 ++
 rtl/conv_line_buffer.sv | 25 ++
 rtl/conv_window_feeder.sv | 186 ++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window feeder: FSM states,
// kernel geometry and the tap-index helper used to pack the ifmap bus.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DONE
  } state_e;

  localparam int KERNEL_DIM  = 3;
  localparam int KERNEL_TAPS = KERNEL_DIM * KERNEL_DIM;

  // First pixel position whose acceptance completes a full 3x3 window.
  localparam int WIN_FIRST_ROW = KERNEL_DIM - 1;
  localparam int WIN_FIRST_COL = KERNEL_DIM - 1;

  // Shift-register column fed by the incoming pixel column (rightmost).
  localparam int WIN_NEW_COL = KERNEL_DIM - 1;

  // Flat tap number of window element (r, c); r=0 top row, c=0 left column.
  function automatic int tap_index(input int r, input int c);
    return KERNEL_DIM * r + c;
  endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel-stream and window-stream handshake bundle of the window feeder.
// master: pixel source / window sink. slave: the feeder itself.
interface conv_window_feeder_if #(
  parameter int DATA_W = 8
);

  logic                                       pix_valid;
  logic [DATA_W-1:0]                          pix_data;
  logic                                       pix_ready;
  logic                                       win_valid;
  logic                                       win_ready;
  logic [conv_pkg::KERNEL_TAPS*DATA_W-1:0]    ifmap;

  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, ifmap
  );

  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, ifmap
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image line of storage: single-port RAM addressed by column.
// The read is combinational so the old entry can be consumed and replaced
// by the new one on the same accepted pixel.
module conv_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the new column entry on each accepted pixel.
  // NOTE: the RAM has no reset; every entry is rewritten before it feeds a window.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream -> 3x3 convolution window stream, plus weight-buffer
// load path. Optional macro CONV_FEEDER_WIN_COUNT_EN adds a saturating
// win_count output counting accepted windows per frame.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  conv_window_feeder_if.slave           bus,
  input  logic [KERNEL_TAPS*DATA_W-1:0] filter_in,
  input  logic                          filter_load,
  output logic [KERNEL_TAPS*DATA_W-1:0] filter,
  output logic                          wb_write_en,
  output logic                          frame_done
`ifdef CONV_FEEDER_WIN_COUNT_EN
  ,
  output logic [15:0]                   win_count
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int WIN_W = KERNEL_TAPS * DATA_W;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               win_valid_q, win_valid_d;
  logic               last_q, last_d;
  logic [WIN_W-1:0]   ifmap_q, ifmap_d;
  logic [WIN_W-1:0]   filter_q;
  logic               wb_write_en_q;

  logic [DATA_W-1:0]  win_q   [KERNEL_DIM][KERNEL_DIM];
  logic [DATA_W-1:0]  new_col [KERNEL_DIM];
  logic [DATA_W-1:0]  lb_top_rd, lb_mid_rd;

  logic pix_ready, accept, consume, frame_go, at_win_pos, at_last_pos;

  assign frame_go    = (state_q == ST_IDLE) && frame_start;
  assign pix_ready   = ((state_q == ST_FILL) || (state_q == ST_STREAM)) &&
                       (!win_valid_q || bus.win_ready);
  assign accept      = bus.pix_valid && pix_ready;
  assign consume     = win_valid_q && bus.win_ready;
  assign at_win_pos  = (row_q >= ROW_W'(WIN_FIRST_ROW)) && (col_q >= COL_W'(WIN_FIRST_COL));
  assign at_last_pos = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

  // Top line holds row-2, middle line holds row-1; the incoming pixel
  // pushes the column one line upward.
  conv_line_buffer #(.WIDTH(DATA_W), .DEPTH(IMG_W)) u_lb_top (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb_mid_rd),
    .rdata_o (lb_top_rd)
  );

  conv_line_buffer #(.WIDTH(DATA_W), .DEPTH(IMG_W)) u_lb_mid (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (bus.pix_data),
    .rdata_o (lb_mid_rd)
  );

  assign new_col[0] = lb_top_rd;
  assign new_col[1] = lb_mid_rd;
  assign new_col[2] = bus.pix_data;

  // Frame sequencing: fill the first two rows, stream windows, one DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_FILL;
      ST_FILL:   if (accept && row_q == ROW_W'(WIN_FIRST_ROW) &&
                     col_q == COL_W'(WIN_FIRST_COL)) state_d = ST_STREAM;
      ST_STREAM: if (consume && last_q) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Raster counters, window register and its valid/last flags.
  // NOTE: every signal takes its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    last_d      = last_q;
    ifmap_d     = ifmap_q;
    if (frame_go) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (consume) win_valid_d = 1'b0;
    // A new window may replace the consumed one in the same cycle.
    if (accept && at_win_pos) begin
      win_valid_d = 1'b1;
      last_d      = at_last_pos;
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM - 1; c++) begin
          ifmap_d[DATA_W*tap_index(r, c) +: DATA_W] = win_q[r][c+1];
        end
        ifmap_d[DATA_W*tap_index(r, WIN_NEW_COL) +: DATA_W] = new_col[r];
      end
    end
  end

  // Control and window state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      last_q      <= 1'b0;
      ifmap_q     <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      last_q      <= last_d;
      ifmap_q     <= ifmap_d;
    end
  end

  // 3x3 shift register: shift left one column per accepted pixel.
  // NOTE: non-blocking assignments make each tap read its neighbour's pre-edge value, so order is irrelevant.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][WIN_NEW_COL] <= new_col[r];
      end
    end
  end

  // Weight-buffer load: capture filter and flag the write one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      filter_q      <= '0;
      wb_write_en_q <= 1'b0;
    end else begin
      wb_write_en_q <= filter_load;
      if (filter_load) filter_q <= filter_in;
    end
  end

`ifdef CONV_FEEDER_WIN_COUNT_EN
  logic [15:0] win_count_q;

  // Saturating count of windows accepted in the current frame.
  always_ff @(posedge clk) begin
    if (rst || frame_go) begin
      win_count_q <= '0;
    end else if (consume && win_count_q != 16'hFFFF) begin
      win_count_q <= win_count_q + 16'd1;
    end
  end

  assign win_count = win_count_q;
`endif

  assign bus.pix_ready = pix_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.ifmap     = ifmap_q;
  assign filter        = filter_q;
  assign wb_write_en   = wb_write_en_q;
  assign frame_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: a 4x4 instance (directed
// frames, stall, filter load, mid-frame reset) and an 8x3 instance (random
// valid/ready gaps). Expected windows come from an image-array model.
module tb_conv_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fs, sel, pv, wr, filter_load;
  logic [7:0]  pd;
  logic [71:0] filter_in, filt_a, filt_b;
  logic        wb_a, wb_b, fd_a, fd_b;
  logic        pr, wv, fd;
  logic [71:0] im;
`ifdef CONV_FEEDER_WIN_COUNT_EN
  logic [15:0] wc_a, wc_b;
`endif

  conv_window_feeder_if #(.DATA_W(8)) bus_a ();
  conv_window_feeder_if #(.DATA_W(8)) bus_b ();

  assign bus_a.pix_valid = pv && !sel;
  assign bus_a.pix_data  = pd;
  assign bus_a.win_ready = wr && !sel;
  assign bus_b.pix_valid = pv && sel;
  assign bus_b.pix_data  = pd;
  assign bus_b.win_ready = wr && sel;

  assign pr = sel ? bus_b.pix_ready : bus_a.pix_ready;
  assign wv = sel ? bus_b.win_valid : bus_a.win_valid;
  assign im = sel ? bus_b.ifmap     : bus_a.ifmap;
  assign fd = sel ? fd_b            : fd_a;

  conv_window_feeder #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .frame_start (fs && !sel),
    .bus         (bus_a),
    .filter_in   (filter_in),
    .filter_load (filter_load),
    .filter      (filt_a),
    .wb_write_en (wb_a),
    .frame_done  (fd_a)
`ifdef CONV_FEEDER_WIN_COUNT_EN
    ,
    .win_count   (wc_a)
`endif
  );

  conv_window_feeder #(.DATA_W(8), .IMG_W(8), .IMG_H(3)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .frame_start (fs && sel),
    .bus         (bus_b),
    .filter_in   (filter_in),
    .filter_load (filter_load),
    .filter      (filt_b),
    .wb_write_en (wb_b),
    .frame_done  (fd_b)
`ifdef CONV_FEEDER_WIN_COUNT_EN
    ,
    .win_count   (wc_b)
`endif
  );

  typedef struct {
    bit          load;
    logic [71:0] din;
    logic [71:0] exp_filter;
    bit          exp_wb;
  } fvec_t;

  typedef struct {
    int         win;
    int         lane;
    logic [7:0] exp;
  } bvec_t;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  img [8][8];
  logic [71:0] exp_q [$];
  logic [71:0] got_q [$];
  fvec_t       fv [5];
  bvec_t       bv [5];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_win_valid", bus_a.win_valid, 0);
    check("rst_pix_ready", bus_a.pix_ready, 0);
    check("rst_frame_done", fd_a, 0);
    check("rst_wb_write_en", wb_a, 0);
    check("rst_ifmap", bus_a.ifmap, 0);
    check("rst_filter", filt_a, 0);
    check("rst_b_win_valid", bus_b.win_valid, 0);
  endtask

  // Streams img (img_w x img_h) into the selected DUT and checks every
  // consumed window against the model. abort_at>=0 stops after that many
  // accepted pixels; stall>0 holds win_ready low after the first window.
  task automatic run_frame(input int img_w, input int img_h, input bit rnd,
                           input int stall, input int abort_at);
    int          pix_idx, fd_cnt, got, stall_rem, exp_n;
    bit          stalled;
    logic [71:0] held, w;
    pix_idx = 0; fd_cnt = 0; got = 0; stall_rem = 0; stalled = 0; held = '0;
    exp_q.delete();
    got_q.delete();
    for (int row = 2; row < img_h; row++) begin
      for (int col = 2; col < img_w; col++) begin
        w = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[8*(3*r+c) +: 8] = img[row-2+r][col-2+c];
        exp_q.push_back(w);
      end
    end
    exp_n = exp_q.size();
    @(negedge clk); fs = 1'b1;
    @(negedge clk); fs = 1'b0;
`ifdef CONV_FEEDER_WIN_COUNT_EN
    if (!sel) check("win_count_clear", wc_a, 0);
`endif
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (fd) fd_cnt++;
      if (abort_at >= 0 && pix_idx >= abort_at) break;
      if (abort_at < 0 && got == exp_n && fd_cnt > 0) break;
      if (stall > 0 && !stalled && wv) begin
        stalled = 1; stall_rem = stall; held = im;
      end
      pv = (pix_idx < img_w*img_h) && (!rnd || $urandom_range(2) != 0);
      pd = (pix_idx < img_w*img_h) ? img[pix_idx / img_w][pix_idx % img_w] : 8'h00;
      wr = (stall_rem > 0) ? 1'b0 : (!rnd || $urandom_range(3) != 0);
      fs = rnd && ($urandom_range(7) == 0);
      #1;
      if (stall_rem > 0) begin
        check("stall_ifmap", im, held);
        check("stall_pix_ready", pr, 0);
        stall_rem--;
      end
      if (pv && pr) pix_idx++;
      if (wv && wr) begin
        got++;
        got_q.push_back(im);
        if (exp_q.size() == 0) check("window_overrun", got, exp_n);
        else check($sformatf("window_%0d", got-1), im, exp_q.pop_front());
      end
    end
    fs = 1'b0;
    pv = 1'b0;
    if (abort_at < 0) begin
      wr = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (fd) fd_cnt++;
      end
      check("frame_windows", got, exp_n);
      check("frame_done_pulses", fd_cnt, 1);
      check("idle_win_valid", wv, 0);
      check("idle_pix_ready", pr, 0);
    end
  endtask

  task automatic check_bytes();
    logic [71:0] w;
    for (int i = 0; i < 5; i++) begin
      if (bv[i].win < got_q.size()) begin
        w = got_q[bv[i].win];
        check($sformatf("byte_w%0d_l%0d", bv[i].win, bv[i].lane), w[8*bv[i].lane +: 8], bv[i].exp);
      end else begin
        check("byte_window_missing", got_q.size(), bv[i].win + 1);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fv[0] = '{1'b1, 72'h090807060504030201, 72'h090807060504030201, 1'b1};
    fv[1] = '{1'b0, 72'hFFFFFFFFFFFFFFFFFF, 72'h090807060504030201, 1'b0};
    fv[2] = '{1'b1, 72'hA5A5A5A5A5A5A5A5A5, 72'hA5A5A5A5A5A5A5A5A5, 1'b1};
    fv[3] = '{1'b1, 72'h123456789ABCDEF012, 72'h123456789ABCDEF012, 1'b1};
    fv[4] = '{1'b0, 72'h000000000000000000, 72'h123456789ABCDEF012, 1'b0};
    bv[0] = '{0, 0, 8'd0};
    bv[1] = '{0, 4, 8'd5};
    bv[2] = '{0, 8, 8'd10};
    bv[3] = '{3, 0, 8'd5};
    bv[4] = '{3, 8, 8'd15};

    rst = 1'b1; fs = 1'b0; sel = 1'b0; pv = 1'b0; wr = 1'b0; pd = '0;
    filter_load = 1'b0; filter_in = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    // Test 1: 4x4 frame, pixels 0..15, win_ready always high.
    for (int i = 0; i < 16; i++) img[i/4][i%4] = 8'(i);
    run_frame(4, 4, 0, 0, -1);
    check_bytes();
`ifdef CONV_FEEDER_WIN_COUNT_EN
    check("win_count_total", wc_a, 4);
`endif

    // Test 2: same frame with a 5-cycle consumer stall after the first window.
    run_frame(4, 4, 0, 5, -1);
    check_bytes();

    // Test 3: weight-buffer load sequence.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      filter_load = fv[i].load;
      filter_in   = fv[i].din;
      @(posedge clk); #1;
      check($sformatf("filter_a_%0d", i), filt_a, fv[i].exp_filter);
      check($sformatf("wb_a_%0d", i), wb_a, fv[i].exp_wb);
      check($sformatf("filter_b_%0d", i), filt_b, fv[i].exp_filter);
      check($sformatf("wb_b_%0d", i), wb_b, fv[i].exp_wb);
    end
    @(negedge clk);
    filter_load = 1'b0;

    // Test 4: reset after 9 accepted pixels, then a clean frame.
    run_frame(4, 4, 0, 0, 9);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    run_frame(4, 4, 0, 0, -1);
    check_bytes();

    // Test 5: 8x3 frame, random pixels with random valid/ready gaps.
    sel = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = 8'($urandom);
    run_frame(8, 3, 1, 0, -1);
    check("b_window_total", got_q.size(), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
